// File: rtl/sdc_card_det_regs.sv
// Card-detect front end: synchronizes and debounces the SD card-detect pin and
// holds the card-detect slice of the host register map (024h/030h/034h/038h) plus its IRQ.
module sdc_card_det_regs #(
  parameter logic [15:0] DEBOUNCE_CNT = 16'd50000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sd_cd_n,
  input  logic [11:0]  rd_reg_index,
  output logic [127:0] rd_reg_input,
  input  logic         wr_reg_strb,
  input  logic [11:0]  wr_reg_index,
  input  logic [31:0]  wr_reg_output,
  input  logic [2:0]   reg_attr,
  output logic         card_inserted_strb,
  output logic         card_removed_strb,
  output logic         card_present,
  output logic         sd_irq
);

  localparam logic [11:0] ADDR_PRES = 12'h024;
  localparam logic [11:0] ADDR_STS  = 12'h030;
  localparam logic [11:0] ADDR_STEN = 12'h034;
  localparam logic [11:0] ADDR_SGEN = 12'h038;
  localparam logic [2:0]  ATTR_RW   = 3'h1;
  localparam logic [2:0]  ATTR_RW1C = 3'h3;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 16'd1);

  logic             cd_meta_r;
  logic             cd_sync_r;
  logic             cd_stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ins_strb_r;
  logic             rem_strb_r;
  logic [1:0]       status_r;
  logic [1:0]       stat_en_r;
  logic [1:0]       sig_en_r;
  logic             irq_r;
  logic [31:0]      rd_data_r;

  logic [CNT_W-1:0] cnt_next_s;
  logic             stable_next_s;
  logic             ins_next_s;
  logic             rem_next_s;
  logic             wr_sts_s;
  logic             wr_sten_s;
  logic             wr_sgen_s;
  logic [1:0]       sts_clr_s;
  logic [1:0]       sts_set_s;
  logic [1:0]       status_next_s;
  logic [31:0]      rd_next_s;

  // Debounce next-state: count while the synchronized level disagrees with the accepted one.
  always_comb begin
    cnt_next_s    = CNT_ZERO;
    stable_next_s = cd_stable_r;
    ins_next_s    = 1'b0;
    rem_next_s    = 1'b0;
    if (cd_sync_r != cd_stable_r) begin
      if (cnt_r == CNT_LAST) begin
        stable_next_s = cd_sync_r;
        ins_next_s    = cd_sync_r;
        rem_next_s    = ~cd_sync_r;
        cnt_next_s    = CNT_ZERO;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_next_s = CNT_ZERO;
    end
  end

  // Synchronizer, debounce counter, accepted level and edge strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cd_meta_r   <= 1'b0;
      cd_sync_r   <= 1'b0;
      cd_stable_r <= 1'b0;
      cnt_r       <= CNT_ZERO;
      ins_strb_r  <= 1'b0;
      rem_strb_r  <= 1'b0;
    end else begin
      cd_meta_r   <= ~sd_cd_n;
      cd_sync_r   <= cd_meta_r;
      cd_stable_r <= stable_next_s;
      cnt_r       <= cnt_next_s;
      ins_strb_r  <= ins_next_s;
      rem_strb_r  <= rem_next_s;
    end
  end

  // Write decode and status update; a strobe setting a bit beats a same-cycle RW1C clear.
  always_comb begin
    wr_sts_s  = wr_reg_strb && (wr_reg_index == ADDR_STS)  && (reg_attr == ATTR_RW1C);
    wr_sten_s = wr_reg_strb && (wr_reg_index == ADDR_STEN) && (reg_attr == ATTR_RW);
    wr_sgen_s = wr_reg_strb && (wr_reg_index == ADDR_SGEN) && (reg_attr == ATTR_RW);
    if (wr_sts_s) begin
      sts_clr_s = wr_reg_output[7:6];
    end else begin
      sts_clr_s = 2'b00;
    end
    sts_set_s     = {rem_strb_r, ins_strb_r} & stat_en_r;
    status_next_s = (status_r & ~sts_clr_s) | sts_set_s;
  end

  // Register-map state: status, status enable, signal enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_r  <= 2'b00;
      stat_en_r <= 2'b11;
      sig_en_r  <= 2'b11;
    end else begin
      status_r <= status_next_s;
      if (wr_sten_s) begin
        stat_en_r <= wr_reg_output[7:6];
      end
      if (wr_sgen_s) begin
        sig_en_r <= wr_reg_output[7:6];
      end
    end
  end

  // Read mux over current register contents; a same-edge write is not yet visible.
  always_comb begin
    rd_next_s = 32'h0000_0000;
    case (rd_reg_index)
      ADDR_PRES: rd_next_s = {13'd0, cd_sync_r, (cnt_r == CNT_ZERO), cd_stable_r, 16'd0};
      ADDR_STS:  rd_next_s = {24'd0, status_r, 6'd0};
      ADDR_STEN: rd_next_s = {24'd0, stat_en_r, 6'd0};
      ADDR_SGEN: rd_next_s = {24'd0, sig_en_r, 6'd0};
      default:   rd_next_s = 32'h0000_0000;
    endcase
  end

  // Registered read data and interrupt line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= 32'h0000_0000;
      irq_r     <= 1'b0;
    end else begin
      rd_data_r <= rd_next_s;
      irq_r     <= |(status_r & sig_en_r);
    end
  end

  assign rd_reg_input       = {96'd0, rd_data_r};
  assign card_inserted_strb = ins_strb_r;
  assign card_removed_strb  = rem_strb_r;
  assign card_present       = cd_stable_r;
  assign sd_irq             = irq_r;

endmodule
